// File: rtl/action_executor_if.sv
// Memory bus between the action executor (master) and the shared SRAM path (slave).
// Reads are combinational: mem_data_i answers the address driven in the same cycle.
interface action_executor_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              mem_ce_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_width_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;

  modport master (
    output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    input  mem_data_i
  );

  modport slave (
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    output mem_data_i
  );
endinterface

// File: rtl/action_executor.sv
// Fetches a 2-word action record and applies it to a packet field in SRAM
// through a read-modify-write on the shared memory bus.
module action_executor #(
  parameter logic [31:0] PKT_BASE = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [31:0]         val_addr_i,
  action_executor_if.master   mem,
  output logic                busy_o,
  output logic                done_o,
  output logic                drop_o,
  output logic                err_o
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned HDR_W  = 20;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_SET  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_DROP = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_FETCH_IMM,
    S_READ_FLD,
    S_WRITE_FLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                start_q;
  logic [ADDR_W-1:0]   va_q, va_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic [DATA_W-1:0]   imm_q, imm_d;

  logic                ce_q, ce_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          width_q, width_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic                err_q, err_d;

  logic                launch_c;
  logic [3:0]          op_c;
  logic [11:0]         off_c;
  logic [3:0]          wcode_c;
  logic                legal_c;
  logic [DATA_W-1:0]   mask_c;
  logic [ADDR_W-1:0]   fld_addr_c;
  logic [DATA_W-1:0]   result_c;

  // Record header fields; only opcode/offset/width are kept from word0.
  assign op_c       = hdr_q[19:16];
  assign off_c      = hdr_q[15:4];
  assign wcode_c    = hdr_q[3:0];
  assign fld_addr_c = PKT_BASE + ADDR_W'(off_c);
  assign launch_c   = start_i & ~start_q;

  // Width legality, natural alignment and truncation mask.
  always_comb begin
    legal_c = 1'b0;
    mask_c  = '0;
    case (wcode_c)
      4'd1: begin legal_c = 1'b1;               mask_c = 32'h0000_00FF; end
      4'd2: begin legal_c = ~off_c[0];          mask_c = 32'h0000_FFFF; end
      4'd4: begin legal_c = (off_c[1:0] == 2'd0); mask_c = 32'hFFFF_FFFF; end
      default: begin legal_c = 1'b0;            mask_c = '0; end
    endcase
    if (op_c > OP_DROP) legal_c = 1'b0;
  end

  // Next state, datapath captures and next registered outputs.
  always_comb begin
    state_d  = state_q;
    va_d     = va_q;
    hdr_d    = hdr_q;
    imm_d    = imm_q;
    drop_d   = drop_q;
    err_d    = err_q;
    ce_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = '0;
    width_d  = '0;
    wdata_d  = '0;
    result_c = '0;

    case (state_q)
      S_IDLE: begin
        if (launch_c) begin
          state_d = S_FETCH_OP;
          va_d    = val_addr_i;
          drop_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_FETCH_OP: begin
        hdr_d   = mem.mem_data_i[31:12];
        state_d = S_FETCH_IMM;
      end
      S_FETCH_IMM: begin
        imm_d = mem.mem_data_i;
        if (!legal_c) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          case (op_c)
            OP_SET:         state_d = S_WRITE_FLD;
            OP_ADD, OP_SUB: state_d = S_READ_FLD;
            OP_DROP: begin
              drop_d  = 1'b1;
              state_d = S_DONE;
            end
            default:        state_d = S_DONE;
          endcase
        end
      end
      S_READ_FLD:  state_d = S_WRITE_FLD;
      S_WRITE_FLD: state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    // Field result: SET comes straight from the IMM being fetched this cycle.
    case (op_c)
      OP_ADD:  result_c = (mem.mem_data_i & mask_c) + imm_q;
      OP_SUB:  result_c = (mem.mem_data_i & mask_c) - imm_q;
      default: result_c = imm_d;
    endcase

    // Bus outputs are registered, so they are derived from the state being entered.
    case (state_d)
      S_FETCH_OP: begin
        ce_d    = 1'b1;
        width_d = 4'd4;
        addr_d  = va_d;
      end
      S_FETCH_IMM: begin
        ce_d    = 1'b1;
        width_d = 4'd4;
        addr_d  = va_q + 32'd4;
      end
      S_READ_FLD: begin
        ce_d    = 1'b1;
        width_d = wcode_c;
        addr_d  = fld_addr_c;
      end
      S_WRITE_FLD: begin
        ce_d    = 1'b1;
        we_d    = 1'b1;
        width_d = wcode_c;
        addr_d  = fld_addr_c;
        wdata_d = result_c & mask_c;
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      va_q    <= '0;
      hdr_q   <= '0;
      imm_q   <= '0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      width_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      va_q    <= va_d;
      hdr_q   <= hdr_d;
      imm_q   <= imm_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      width_q <= width_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign mem.mem_ce_o    = ce_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_width_o = width_q;
  assign mem.mem_data_o  = wdata_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign drop_o          = drop_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_action_executor.sv
// Bench for action_executor: byte-array SRAM model with combinational reads,
// directed cases plus random records checked against an arithmetic reference model.
module tb_action_executor;

  localparam logic [31:0] PKT_BASE = 32'h0000_0000;
  localparam int unsigned MEM_BYTES = 8192;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] val_addr_i;
  logic        busy_o, done_o, drop_o, err_o;

  action_executor_if bus();

  action_executor #(.PKT_BASE(PKT_BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .val_addr_i (val_addr_i),
    .mem        (bus.master),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .drop_o     (drop_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [MEM_BYTES];

  int n_checks = 0;
  int n_fail   = 0;

  int          acc_cnt  = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [31:0] last_addr  = '0;
  logic [3:0]  last_width = '0;
  logic [31:0] last_data  = '0;

  function automatic logic [31:0] rd(input logic [31:0] a, input logic [3:0] w);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(w)) d[8*i +: 8] = mem[int'((a + 32'(i)) & 32'h1FFF)];
    return d;
  endfunction

  always_comb begin
    if (bus.mem_ce_o && !bus.mem_we_o) bus.mem_data_i = rd(bus.mem_addr_o, bus.mem_width_o);
    else                               bus.mem_data_i = 32'h0;
  end

  // Bus monitor: writes are logged, not applied, so the array has a single writer.
  always @(posedge clk) begin
    if (bus.mem_ce_o) acc_cnt++;
    if (bus.mem_ce_o && bus.mem_we_o) begin
      wr_cnt++;
      last_addr  = bus.mem_addr_o;
      last_width = bus.mem_width_o;
      last_data  = bus.mem_data_o;
    end
    if (done_o) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic put8(input logic [31:0] a, input logic [7:0] v);
    mem[int'(a & 32'h1FFF)] = v;
  endtask

  task automatic put32(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) put8(a + 32'(i), v[8*i +: 8]);
  endtask

  // Reference: outcome of an action record against the current packet image.
  task automatic model(input logic [31:0] w0, input logic [31:0] imm,
                       output bit e_err, output bit e_drop, output bit e_wr,
                       output logic [31:0] e_addr, output logic [3:0] e_w,
                       output logic [31:0] e_data, output int e_lat);
    int unsigned op, off, w;
    longint unsigned modv, fld, iv;
    op  = int'(w0 >> 28);
    off = int'((w0 >> 16) & 32'hFFF);
    w   = int'((w0 >> 12) & 32'hF);
    e_err  = (op > 4) || !(w == 1 || w == 2 || w == 4) || ((off % w) != 0);
    e_drop = 0;
    e_wr   = 0;
    e_lat  = 4;
    e_addr = PKT_BASE + 32'(off);
    e_w    = 4'(w);
    e_data = '0;
    if (!e_err) begin
      modv = 64'd1 << (8 * w);
      fld  = 64'(rd(e_addr, 4'(w)));
      iv   = 64'(imm) % modv;
      case (op)
        1: begin e_wr = 1; e_lat = 5; e_data = 32'(iv); end
        2: begin e_wr = 1; e_lat = 6; e_data = 32'((fld + iv) % modv); end
        3: begin e_wr = 1; e_lat = 6; e_data = 32'((fld + modv - iv) % modv); end
        4: e_drop = 1;
        default: ;
      endcase
    end
  endtask

  task automatic run_action(input logic [31:0] w0, input logic [31:0] imm,
                            input logic [31:0] va, input bit hold);
    bit e_err, e_drop, e_wr, got;
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_w;
    int e_lat, cyc, wr0, d0;
    put32(va, w0);
    put32(va + 32'd4, imm);
    model(w0, imm, e_err, e_drop, e_wr, e_addr, e_w, e_data, e_lat);
    wr0 = wr_cnt;
    d0  = done_cnt;
    start_i    = 1'b1;
    val_addr_i = va;
    cyc = 1;
    got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) begin
        check("busy_after_launch", 32'(busy_o), 32'd1);
        check("drop_cleared", 32'(drop_o), 32'd0);
        check("err_cleared", 32'(err_o), 32'd0);
        val_addr_i = $urandom;
        if (!hold) start_i = 1'b0;
      end
      if (done_o) got = 1;
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc), 32'(e_lat));
    check("drop", 32'(drop_o), 32'(e_drop));
    check("err", 32'(err_o), 32'(e_err));
    check("write_count", 32'(wr_cnt - wr0), 32'(e_wr));
    if (e_wr) begin
      check("write_addr", last_addr, e_addr);
      check("write_width", 32'(last_width), 32'(e_w));
      check("write_data", last_data, e_data);
    end
    @(posedge clk); #1;
    check("done_pulse_len", 32'(done_o), 32'd0);
    check("busy_released", 32'(busy_o), 32'd0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] all_outputs();
    return {23'(0), bus.mem_ce_o, bus.mem_we_o, busy_o, done_o, drop_o, err_o, 3'(0)} |
           bus.mem_addr_o | 32'(bus.mem_width_o) | bus.mem_data_o;
  endfunction

  initial begin
    int wr0, d0, acc0;
    logic [31:0] w0, va;
    int unsigned op, w, off;

    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    start_i = 1'b0;
    val_addr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SET 16-bit
    put8(PKT_BASE + 32'd4, 8'h34);
    put8(PKT_BASE + 32'd5, 8'h12);
    run_action(32'h1004_2000, 32'h0000_ABCD, 32'h0000_1100, 1'b0);
    check("set_data_const", last_data, 32'h0000_ABCD);

    // ADD 8-bit wrap
    put8(PKT_BASE + 32'd16, 8'hF0);
    run_action(32'h2010_1000, 32'h0000_0025, 32'h0000_1108, 1'b1);
    check("add_wrap_const", last_data, 32'h0000_0015);

    // SUB 32-bit underflow
    put32(PKT_BASE + 32'd8, 32'h0);
    run_action(32'h3008_4000, 32'h0000_0001, 32'h0000_1110, 1'b0);
    check("sub_wrap_const", last_data, 32'hFFFF_FFFF);

    // DROP, then illegal opcode, bad width, misaligned offset
    run_action(32'h4000_1000, 32'h0, 32'h0000_1118, 1'b0);
    check("drop_set", 32'(drop_o), 32'd1);
    run_action(32'h7000_1000, 32'h0, 32'h0000_1120, 1'b0);
    run_action(32'h1000_3000, 32'h5, 32'h0000_1128, 1'b0);
    run_action(32'h1003_2000, 32'h5, 32'h0000_1130, 1'b0);
    run_action(32'h0000_1000, 32'h0, 32'h0000_1138, 1'b0);

    // Level held for 20 cycles launches exactly once
    put32(32'h0000_1140, 32'h1000_1000);
    put32(32'h0000_1144, 32'h0000_0077);
    wr0 = wr_cnt; d0 = done_cnt;
    start_i = 1'b1; val_addr_i = 32'h0000_1140;
    repeat (20) @(posedge clk);
    #1; start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_done_count", 32'(done_cnt - d0), 32'd1);
    check("hold_write_count", 32'(wr_cnt - wr0), 32'd1);

    // Toggling start_i while busy (including a rise during DONE) is ignored
    wr0 = wr_cnt; d0 = done_cnt;
    start_i = 1'b1;
    for (int c = 2; c <= 6; c++) begin
      @(posedge clk); #1;
      start_i = (c == 3 || c == 5) ? 1'b1 : 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
    check("toggle_done_count", 32'(done_cnt - d0), 32'd1);
    check("toggle_write_count", 32'(wr_cnt - wr0), 32'd1);
    check("toggle_idle", 32'(busy_o), 32'd0);

    // Reset in READ_FLD aborts before the write
    put32(32'h0000_1150, 32'h2010_1000);
    put32(32'h0000_1154, 32'h0000_0001);
    wr0 = wr_cnt; d0 = done_cnt;
    start_i = 1'b1; val_addr_i = 32'h0000_1150;
    @(posedge clk); #1; start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("readfld_ce", 32'({bus.mem_ce_o, bus.mem_we_o}), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_outputs", all_outputs(), 32'd0);
    acc0 = acc_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_access", 32'(acc_cnt - acc0), 32'd0);
    check("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_action(32'h2010_1000, 32'h0000_0001, 32'h0000_1150, 1'b0);

    // Random records
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      if (op > 5) op = $urandom_range(1, 3);
      case ($urandom_range(0, 9))
        0:       w = 3;
        1:       w = 0;
        2, 3, 4: w = 1;
        5, 6:    w = 2;
        default: w = 4;
      endcase
      off = $urandom_range(0, 4095);
      if ((w == 2 || w == 4) && $urandom_range(0, 7) != 0) off = off - (off % w);
      put32(PKT_BASE + 32'(off), $urandom);
      w0 = {4'(op), 12'(off), 4'(w), 12'($urandom)};
      va = 32'h0000_1200 + 32'(8 * $urandom_range(0, 600));
      run_action(w0, $urandom, va, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/action_executor.md
Name: action_executor

Overview:
- Stage directly downstream of matcher. It consumes matcher's ready_o / val_addr_o, fetches the 2-word action record at val_addr, and applies it to the packet held in SRAM.
- Access is a read-modify-write through the shared mem/sram path.
- Reports completion, drop and error to the next stage (egress/deparser).

Parameters:
- PKT_BASE, 32'h0000_0000: byte address of packet byte 0 in SRAM.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  matcher ready_o; a rising edge launches one action.
- val_addr_i  in  `DATA_BUS  matcher val_addr_o; byte address of the action record.
- mem_ce_o  out  1  memory access enable.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  `ADDR_BUS  byte address.
- mem_width_o  out  4  access width in bytes (1, 2 or 4).
- mem_data_o  out  `DATA_BUS  write data, right-aligned.
- mem_data_i  in  `DATA_BUS  read data, right-aligned.
- busy_o  out  1  action in progress.
- done_o  out  1  one-cycle completion pulse.
- drop_o  out  1  packet marked for drop; sticky until next launch.
- err_o  out  1  illegal action; sticky until next launch.

Behaviour:
- Clocking and reset
  - Single clock. Reset is synchronous and active-high, applied on posedge clk when rst=1.
  - Reset values: state=IDLE; all outputs 0 (mem_* 0, busy_o/done_o/drop_o/err_o 0); start_q=0.
- Memory read timing
  - A read is combinational through mem/sram.
  - mem_data_i is valid in the same cycle that ce=1, we=0 and addr are driven; it is captured at the following posedge.
- Action record format
  - Word0 at val_addr: [31:28] opcode, [27:16] byte offset OFF, [15:12] width code W (1, 2 or 4), [11:0] reserved (ignored).
  - Word1 at val_addr+4: immediate IMM.
- Opcodes
  - 0 NOP.
  - 1 SET: field = IMM.
  - 2 ADD: field = field + IMM.
  - 3 SUB: field = field - IMM.
  - 4 DROP: drop_o = 1, no memory write.
  - 5-15: illegal.
- Arithmetic
  - Computed on 32 bits, then truncated to W*8 bits (modular wrap).
  - IMM is truncated the same way.
  - Upper bits of mem_data_o are 0.
- Launch
  - launch = start_i & ~start_q, where start_q is start_i registered every cycle.
  - A level held high does not relaunch.
  - launch is honoured only in IDLE; it is ignored while busy_o=1.
- FSM (one state per cycle)
  - IDLE: on launch, latch val_addr_i, clear drop_o/err_o, busy_o=1, go to FETCH_OP.
  - FETCH_OP: read width 4 at val_addr. Capture word0. Go to FETCH_IMM.
  - FETCH_IMM: read width 4 at val_addr+4. Capture IMM. Then decode:
    - illegal opcode, or W not in {1,2,4}, or OFF % W != 0: err_o=1, go to DONE.
    - NOP: go to DONE.
    - DROP: drop_o=1, go to DONE.
    - SET: go to WRITE_FLD.
    - ADD/SUB: go to READ_FLD.
  - READ_FLD: read width W at PKT_BASE+OFF. Capture the field. Go to WRITE_FLD.
  - WRITE_FLD: ce=1, we=1, width W, addr PKT_BASE+OFF, data = result. Go to DONE.
  - DONE: done_o=1, busy_o=0 next cycle, go to IDLE.
- Memory outputs outside access states: mem_ce_o=0, mem_we_o=0; address and data are don't-care but held at 0.
- Latency from launch cycle to done_o, inclusive:
  - NOP/DROP/err: 4 cycles.
  - SET: 5 cycles.
  - ADD/SUB: 6 cycles.
- Exactly one write per SET/ADD/SUB; no write for any other outcome.
- rst mid-operation aborts at that edge: no further memory accesses, and all outputs return to reset values the next cycle. A write already performed is not undone.
- val_addr_i changes after launch have no effect.
- start_i falling mid-operation has no effect.
- start_i rising again during DONE is ignored; a fresh rising edge in IDLE is required.

Test Plan:
- SET: word0=32'h1004_2000 (OFF=4, W=2), IMM=32'h0000_ABCD, packet bytes[4:5]=0x1234 → one write, width 2, addr PKT_BASE+4, data 0x0000ABCD; done_o 5 cycles after launch; drop_o=0, err_o=0.
- ADD wrap: word0=32'h2010_1000 (OFF=16, W=1), field=0xF0, IMM=0x25 → read 0xF0, write 0x15; done_o at cycle 6.
- SUB 32-bit: OFF=8, W=4, field=0, IMM=1 → write 0xFFFF_FFFF.
- DROP and illegal: opcode 4 → drop_o=1 with no write; opcode 7, or W=3, or OFF=3 with W=2 → err_o=1 with no write; each completes at cycle 4.
- Handshake: hold start_i high for 20 cycles → exactly one action and one done_o. Toggle start_i during busy_o → ignored. Drop then re-raise start_i in IDLE → second action; drop_o/err_o cleared at launch.
- Reset mid-op: assert rst in READ_FLD → no write; next cycle all outputs 0 and state IDLE; a subsequent launch works normally.
